// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan controller.
package seg7_pkg;

    // Scan FSM: all anodes off (guard) or one digit lit (display)
    typedef enum logic [0:0] {
        StGuard,
        StDisplay
    } scan_state_e;

    // Active-low segments, everything off
    localparam logic [6:0] SegBlank = 7'b1111111;

    // Default timing
    localparam int unsigned DefNumDigits   = 4;
    localparam int unsigned DefDigitCycles = 50000;
    localparam int unsigned DefGuardCycles = 500;

endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// Hex nibble to active-low 7-segment decoder; seg = {g,f,e,d,c,b,a}.
module seg7_scan_ctrl_dec (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup of the glyph for one hex digit
    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_ctrl import seg7_pkg::*; #(
    parameter int unsigned NUM_DIGITS   = DefNumDigits,
    parameter int unsigned DIGIT_CYCLES = DefDigitCycles,
    parameter int unsigned GUARD_CYCLES = DefGuardCycles
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int unsigned MaxCycles = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES
                                                                      : GUARD_CYCLES;
    localparam int unsigned CntW  = $clog2(MaxCycles + 1);
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DataW = 4 * NUM_DIGITS;

    localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);
    localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [DataW-1:0]        pending_q, shadow_q;
    logic                    pending_valid_q;
    logic                    frame_start;
    logic [3:0]              nibble;
    logic [6:0]              seg_dec;
    logic                    lz_blank;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic                    frame_d;

    // FSM state, slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StGuard;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: guard -> display -> guard, advancing the digit after each display slot
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        frame_start = 1'b0;
        if (!en) begin
            state_d = StGuard;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StGuard: begin
                    if (cnt_q == GuardLast) begin
                        state_d     = StDisplay;
                        cnt_d       = '0;
                        frame_start = (idx_q == '0);
                    end
                end
                StDisplay: begin
                    if (cnt_q == DigitLast) begin
                        state_d = StGuard;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StGuard;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double buffer: shadow only changes at a frame boundary so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            shadow_q        <= '0;
        end else begin
            if (load) begin
                pending_q <= data_in;
            end
            if (frame_start && pending_valid_q) begin
                shadow_q <= pending_q;
            end
            // A load on the transfer cycle keeps the new value pending
            if (load) begin
                pending_valid_q <= 1'b1;
            end else if (frame_start) begin
                pending_valid_q <= 1'b0;
            end
        end
    end

    // Select the shadow nibble for the current digit
    always_comb begin
        nibble = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                nibble = shadow_q[i*4 +: 4];
            end
        end
    end

    seg7_scan_ctrl_dec u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

`ifdef SEG7_LZ_BLANK_EN
    // Blank digit idx>0 when it and every more-significant nibble are zero
    always_comb begin
        lz_blank = (idx_q != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IdxW'(i) >= idx_q && shadow_q[i*4 +: 4] != 4'h0) begin
                lz_blank = 1'b0;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Output decode from the state register; en low darkens the pins on the next edge
    always_comb begin
        seg_d   = SegBlank;
        an_d    = '1;
        frame_d = 1'b0;
        if (en && state_q == StDisplay) begin
            frame_d = (idx_q == '0) && (cnt_q == '0);
            if (!lz_blank) begin
                seg_d = seg_dec;
                an_d  = ~(NUM_DIGITS'(1) << idx_q);
            end
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg   <= SegBlank;
            an    <= '1;
            frame <= 1'b0;
        end else begin
            seg   <= seg_d;
            an    <= an_d;
            frame <= frame_d;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one seg7 decoder. Latches a multi-digit hex value, then walks the digits round-robin, driving one anode at a time with a blanking guard interval between digits to prevent ghosting. Sits between the datapath registers that produce display values and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- DIGIT_CYCLES, 50000, clock cycles each digit is lit (>=1)
- GUARD_CYCLES, 500, clock cycles all anodes are off between digits (>=1)

- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  scan enable; low forces display dark
- load  in  1  single-cycle strobe capturing data_in
- data_in  in  4*NUM_DIGITS  hex nibbles; [3:0] = digit 0 (rightmost)
- seg  out  7  segment drive, active-low, from seg7 encoding
- an  out  NUM_DIGITS  anode drive, active-low; an[i] lights digit i
- frame  out  1  one-cycle pulse at start of each scan frame

## Operation
- Registers: pending (4*NUM_DIGITS), pending_valid, shadow (4*NUM_DIGITS), idx, cycle counter, state.
- load: pending <= data_in, pending_valid <= 1. Repeated loads overwrite pending.
- FSM states GUARD, DISPLAY.
  - GUARD: an all 1, seg 7'b1111111; counts GUARD_CYCLES, then -> DISPLAY.
  - DISPLAY: an[idx]=0, others 1; seg = seg7(shadow nibble idx); counts DIGIT_CYCLES, then -> GUARD with idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary = GUARD->DISPLAY transition with idx==0: if pending_valid, shadow <= pending, pending_valid <= 0; frame pulses. Shadow never changes mid-frame (no tearing).
- load coinciding with frame-boundary transfer: shadow takes old pending, pending takes new data_in, pending_valid stays 1.
- en low: next cycle state=GUARD, idx=0, counter=0, frame=0; pending still accepts loads. en rising: scan restarts with full GUARD then digit 0 (frame boundary applies).
- Counter width $clog2(max(DIGIT_CYCLES,GUARD_CYCLES)+1); counter reset to 0 on every state change.

## Timing
- Reset values: state GUARD, idx 0, counter 0, pending/shadow 0, pending_valid 0, an all 1, seg 7'b1111111, frame 0.
- seg, an, frame are registered: pins reflect state one cycle after the state register.
- First digit lit GUARD_CYCLES+1 cycles after rst_n release with en high.
- Frame period NUM_DIGITS*(DIGIT_CYCLES+GUARD_CYCLES) cycles.
- load to visible: at most one frame period plus GUARD_CYCLES+1 cycles.
- Reset mid-frame: outputs dark immediately (asynchronous), pending load lost.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking. During DISPLAY of digit i>0, if shadow nibbles i..NUM_DIGITS-1 are all zero, an stays all 1 (slot timing unchanged). Digit 0 never blanked.
- Undefined: every digit lit, zeros shown as "0".

## Structure
- seg7_pkg: scan state enum (GUARD, DISPLAY), blank segment constant 7'b1111111, default timing constants.
- One sub-module: existing seg7 decoder, instanced once, fed shadow nibble idx.

## Test plan
Use NUM_DIGITS=4, DIGIT_CYCLES=8, GUARD_CYCLES=2.
- Reset release, en=1, no load -> an=4'b1111 for 3 cycles, then an=4'b1110, seg=7'b1000000 for 8 cycles; frame pulses once every 40 cycles.
- load data_in=16'h12AF mid-frame -> current frame unchanged; next frame shows digit0 seg 7'b0001110 (F), digit1 7'b0001000 (A), digit2 7'b0100100 (2), digit3 7'b1111001 (1).
- load 16'h0001 then 16'h0002 in same frame -> only 2 (7'b0100100) ever displayed on digit 0.
- load asserted on frame-boundary cycle -> shadow gets prior pending, new value shown one frame later.
- en dropped during digit 2 -> an=4'b1111 next cycle; en restored -> 2 guard cycles, then digit 0 with frame pulse.
- SEG7_LZ_BLANK_EN defined, data 16'h0030 -> digits 0,1 lit, digits 2,3 slots keep an=4'b1111; undefined -> all four lit.
